rr_arbiter_n: RTL and testbench

Parametrised N-requester round-robin arbiter with registered one-hot grant, grant ownership held while the owner keeps requesting, and rotating priority. The rotation advances only when a grant ends, not on every clock. An optional burst limit forces the grant to rotate after a fixed number of cycles. It sits in front of any shared resource (bus, memory port, FIFO write side) in place of the fixed 3-input combinational arbiter, and is the common arbitration primitive for multi-channel blocks.

---
 rtl/rr_arbiter_n.sv | 164 ++++++++++++++++
 tb/tb_rr_arbiter_n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with a registered one-hot grant.
//
// The current owner keeps the grant for as long as it keeps requesting. When it
// drops its request, the priority pointer moves to the requester after it and
// the arbiter re-arbitrates at that same edge, so back-to-back owners see no
// idle cycle. The pointer moves only when a grant ends, not on every clock.
//
// Optional feature, enabled by defining RR_ARB_BURST_LIMIT_EN:
//   After MAX_BURST consecutive grant cycles, the owner is forced to give way
//   to the next active requester. The owner is searched last. If nobody else
//   is requesting, the owner is granted again and its burst count restarts.
//   Without the macro there is no counter, and MAX_BURST only takes part in
//   the parameter range check.
//
// All outputs are flops. There is no combinational path from req to any output.

module rr_arbiter_n #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    localparam int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    // Stop the build on an illegal configuration instead of producing odd hardware.
    if (N < 2 || N > 32 || MAX_BURST < 1) begin : g_bad_param
        $error("rr_arbiter_n: need 2 <= N <= 32 and MAX_BURST >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [N-1:0]    ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N - 1);

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam int             CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
`endif

    state_t          state;
    logic [ID_W-1:0] ptr;

`ifdef RR_ARB_BURST_LIMIT_EN
    // Counts the owner's grant cycles. It is 0 during the first cycle of a grant.
    logic [CNT_W-1:0] burst_cnt;
`endif

    // Search results: one from the stored pointer, used when leaving IDLE, and
    // one from the requester after the owner, used on release or burst expiry.
    logic            ptr_found;
    logic [ID_W-1:0] ptr_idx;
    logic            rot_found;
    logic [ID_W-1:0] rot_idx;
    logic [ID_W-1:0] rot_ptr;
    logic            owner_req;

    // Returns {found, index} of the first set bit of r, scanning upward from
    // start and wrapping past N-1 to 0.
    function automatic logic [ID_W:0] rr_search(input logic [N-1:0]    r,
                                                input logic [ID_W-1:0] start);
        logic            found;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            int              pos;
            logic [ID_W-1:0] cand;
            pos = int'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = ID_W'(pos);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Work out the pointer after the owner, and both arbitration candidates.
    always_comb begin
        rot_ptr   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        owner_req = req[grant_id];
        {ptr_found, ptr_idx} = rr_search(req, ptr);
        {rot_found, rot_idx} = rr_search(req, rot_ptr);
    end

    // FSM, pointer, burst counter and registered grant outputs.
    // NOTE: every register here uses a non-blocking assignment. Each state bit
    // and each output then takes its value from the pre-edge state, however the
    // branches below are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef RR_ARB_BURST_LIMIT_EN
            burst_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ptr_found) begin
                        state       <= BUSY;
                        grant       <= ONE_HOT_0 << ptr_idx;
                        grant_valid <= 1'b1;
                        grant_id    <= ptr_idx;
`ifdef RR_ARB_BURST_LIMIT_EN
                        burst_cnt   <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (!owner_req) begin
                        // The owner has released. The requester after it gets
                        // first chance at this same edge.
                        ptr <= rot_ptr;
                        if (rot_found) begin
                            grant    <= ONE_HOT_0 << rot_idx;
                            grant_id <= rot_idx;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                        end
`ifdef RR_ARB_BURST_LIMIT_EN
                        burst_cnt <= '0;
`endif
                    end
`ifdef RR_ARB_BURST_LIMIT_EN
                    else if (burst_cnt == CNT_LAST) begin
                        // The burst has expired. The owner still requests, so
                        // the search always finds someone, at worst the owner.
                        ptr       <= rot_ptr;
                        grant     <= ONE_HOT_0 << rot_idx;
                        grant_id  <= rot_idx;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: directed, table-driven bench for rr_arbiter_n (N=4, MAX_BURST=4).
// Builds with or without RR_ARB_BURST_LIMIT_EN. Expectations follow that macro.

module tb_rr_arbiter_n;

    localparam int N         = 4;
    localparam int MAX_BURST = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_n #(
        .N         (N),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [3:0] r,
                       input logic [3:0] g, input logic [1:0] id);
        vec_t v;
        v.rst   = rst;
        v.req   = r;
        v.grant = g;
        v.id    = id;
        vecs.push_back(v);
    endtask

    // Compares all three outputs against the expected grant. grant_valid is
    // expected to equal |grant.
    task automatic check(input string name, input logic [3:0] exp_g, input logic [1:0] exp_id);
        logic exp_v;
        exp_v = (exp_g != 4'b0000);
        total++;
        if (grant !== exp_g || grant_id !== exp_id || grant_valid !== exp_v) begin
            bad++;
            $display("FAIL %s: got grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                     name, grant, grant_id, grant_valid, exp_g, exp_id, exp_v);
        end
    endtask

    // Drives one cycle of inputs, clocks it, and checks the outputs 1 time unit
    // after the edge.
    task automatic step(input string name, input logic rst, input logic [3:0] r,
                        input logic [3:0] exp_g, input logic [1:0] exp_id);
        reset = rst;
        req   = r;
        @(posedge clk);
        #1;
        check(name, exp_g, exp_id);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;

        // The fixed scenario, one record per clock.
        add(1, 4'b1111, 4'b0000, 2'd0); // reset ignores req
        add(0, 4'b0100, 4'b0100, 2'd2); // owner 2
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0100, 4'b0000, 2'd0); // reset mid-grant
        add(0, 4'b1111, 4'b0001, 2'd0); // ptr back to 0
        // rotation: each owner drops its req for one cycle after two grant cycles
        add(0, 4'b1111, 4'b0001, 2'd0);
        add(0, 4'b1110, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0010, 2'd1);
        add(0, 4'b1101, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0100, 2'd2);
        add(0, 4'b1011, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b1000, 2'd3);
        add(0, 4'b0111, 4'b0001, 2'd0); // wrap 3 -> 0
        add(0, 4'b1110, 4'b0010, 2'd1);
        add(0, 4'b0000, 4'b0000, 2'd0); // idle, ptr=2
        add(0, 4'b0011, 4'b0001, 2'd0); // search 2,3,0
        add(0, 4'b0000, 4'b0000, 2'd0); // ptr=1
        add(0, 4'b0011, 4'b0010, 2'd1); // search starts at 1
        add(0, 4'b0000, 4'b0000, 2'd0); // ptr=2
        // wrap-around: req[3] alone for 3 cycles, then idle with ptr=0
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b1001, 4'b0001, 2'd0);
        add(0, 4'b0000, 4'b0000, 2'd0); // ptr=1
        // release together with new requests: the releaser ranks last
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(0, 4'b1011, 4'b1000, 2'd3);
        add(0, 4'b0111, 4'b0001, 2'd0);
        add(0, 4'b0110, 4'b0010, 2'd1);
        add(0, 4'b0000, 4'b0000, 2'd0); // ptr=2

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].id);
        end

        // Owner 1 is granted from ptr=2: the search order is 2,3,0,1.
        step("own1", 0, 4'b0010, 4'b0010, 2'd1);
`ifndef RR_ARB_BURST_LIMIT_EN
        // Hold: other requesters toggle but never take the grant from owner 1.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] r;
            r = 4'b0010;
            r[0] = i[0];
            r[3] = i[1];
            step($sformatf("hold%0d", i), 0, r, 4'b0010, 2'd1);
        end
        // Release: the search starts at 2. req[2]=0, so requester 3 wins.
        step("release", 0, 4'b1001, 4'b1000, 2'd3);
`else
        // Owner 1 releases. Only req[3] is set, so requester 3 wins.
        step("release", 0, 4'b1000, 4'b1000, 2'd3);
`endif
        step("idle0", 0, 4'b0000, 4'b0000, 2'd0); // ptr=0

`ifdef RR_ARB_BURST_LIMIT_EN
        // Burst limit of 4: the two requesters alternate every 4 cycles.
        for (int i = 0; i < 12; i++) begin
            logic [3:0] eg;
            logic [1:0] eid;
            eid = ((i / MAX_BURST) % 2 == 1) ? 2'd1 : 2'd0;
            eg  = (eid == 2'd1) ? 4'b0010 : 4'b0001;
            step($sformatf("burst%0d", i), 0, 4'b0011, eg, eid);
        end
        // With a single requester, the owner is granted again each time.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("solo%0d", i), 0, 4'b0001, 4'b0001, 2'd0);
        end
`else
        // No burst limit: owner 0 holds the grant indefinitely.
        for (int i = 0; i < 50; i++) begin
            step($sformatf("nolimit%0d", i), 0, 4'b0011, 4'b0001, 2'd0);
        end
`endif

        step("end_reset", 1, 4'b1111, 4'b0000, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
